// File: rtl/apb_pkg.sv
// apb_pkg: shared APB requester state, response record and PPROT field constants
package apb_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_req_state_e;
    localparam int APB_DATA_MAX = 32;
    typedef struct packed {
        logic [APB_DATA_MAX-1:0] rdata;
        logic                    slverr;
        logic                    timeout;
    } apb_rsp_t;
    localparam logic [2:0] PPROT_PRIV   = 3'b001;
    localparam logic [2:0] PPROT_NONSEC = 3'b010;
    localparam logic [2:0] PPROT_INSTR  = 3'b100;
endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: saturating count of ACCESS wait states, flags when the limit is reached
module apb_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (enable && count != LIMIT) count <= count + 1'b1;
    end
    assign expired = TIMEOUT_CYCLES != 0 && count == LIMIT;
endmodule

// File: rtl/apb_requester.sv
// apb_requester: single-outstanding APB4 requester bridging a valid/ready command/response port
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic                    rsp_timeout,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [2:0]              PPROT,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);
    apb_req_state_e state, state_n;
    apb_rsp_t       rsp_q;
    logic           accept, done, timeout, expired;

    assign accept = state == IDLE && cmd_valid;
    assign done = state == ACCESS && PREADY;
    assign timeout = state == ACCESS && !PREADY && expired;

    apb_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(PCLK),
        .rst(PRESET),
        .clear(accept),
        .enable(state == ACCESS && !PREADY),
        .expired(expired)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = accept ? SETUP :
                  state == SETUP ? ACCESS :
                  (done || timeout) ? RESP :
                  (state == RESP && rsp_ready) ? IDLE : state;
    end

    // Bus fields are captured once at acceptance and then simply held.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
            PPROT  <= '0;
            rsp_q  <= '0;
        end else begin
            if (accept) begin
                PADDR  <= cmd_addr;
                PWRITE <= cmd_write;
                PWDATA <= cmd_wdata;
                PSTRB  <= cmd_write ? cmd_strb : '0;
                PPROT  <= cmd_prot;
            end
            if (done) begin
                rsp_q.rdata   <= PWRITE ? '0 : APB_DATA_MAX'(PRDATA);
                rsp_q.slverr  <= PSLVERR;
                rsp_q.timeout <= 1'b0;
            end else if (timeout) begin
                rsp_q.rdata   <= '0;
                rsp_q.slverr  <= 1'b1;
                rsp_q.timeout <= 1'b1;
            end
        end
    end

    assign cmd_ready   = state == IDLE;
    assign PSEL        = state == SETUP || state == ACCESS;
    assign PENABLE     = state == ACCESS;
    assign rsp_valid   = state == RESP;
    assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
    assign rsp_slverr  = rsp_q.slverr;
    assign rsp_timeout = rsp_q.timeout;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: randomized bench for apb_requester against a transfer-timeline model
module tb_apb_requester;
    import apb_pkg::*;
    localparam int TO = 16;

    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic [2:0]  cmd_prot = '0;
    logic        cmd_ready, rsp_valid, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA = '0;
    logic [2:0]  PPROT;
    logic [3:0]  PSTRB;
    logic        PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;

    int          n_cmp = 0, n_bad = 0;
    logic        checking = 1'b0;
    int          cur_waits = 0;
    logic        cur_err = 1'b0;
    logic [31:0] cur_rdata = '0;

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PPROT(PPROT), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Completer: PREADY rises after cur_waits ACCESS cycles; junk on PRDATA/PSLVERR otherwise.
    int acc_cnt = 0;
    always @(posedge PCLK) begin
        #1;
        if (PSEL && PENABLE) begin
            PREADY = (acc_cnt == cur_waits);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            PREADY = 1'($urandom);
        end
        PRDATA  = (PREADY && PSEL && PENABLE) ? cur_rdata : $urandom;
        PSLVERR = (PREADY && PSEL && PENABLE) ? cur_err : 1'($urandom);
    end

    // Model: age = cycles since acceptance; a transfer is SETUP, acc_len ACCESS cycles, then response.
    int          age = 0, acc_len = 1, cyc = 0, acc_cyc = 0, gap = 0;
    logic [31:0] m_addr, m_wdata, m_rdata, n_rdata;
    logic        m_write, m_err, m_to, n_err, n_to;
    logic [3:0]  m_strb;
    logic [2:0]  m_prot;
    always @(posedge PCLK) begin
        cyc++;
        if (PRESET) begin
            age = 0; m_addr = '0; m_wdata = '0; m_write = 1'b0; m_strb = '0; m_prot = '0;
            m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
        end else if (age == 0) begin
            if (cmd_valid) begin
                age = 1; gap = cyc - acc_cyc; acc_cyc = cyc;
                m_addr = cmd_addr; m_write = cmd_write; m_wdata = cmd_wdata; m_prot = cmd_prot;
                m_strb = cmd_write ? cmd_strb : 4'h0;
                n_to = TO != 0 && cur_waits > TO;
                acc_len = n_to ? TO + 1 : cur_waits + 1;
                n_rdata = (n_to || cmd_write) ? 32'h0 : cur_rdata;
                n_err = n_to || cur_err;
            end
        end else if (age == 2 + acc_len) begin
            if (rsp_ready) age = 0;
        end else begin
            if (age == 1 + acc_len) begin
                m_rdata = n_rdata; m_err = n_err; m_to = n_to;
            end
            age++;
        end
    end

    always @(negedge PCLK) begin
        if (checking) begin
            chk("cmd_ready", 64'(cmd_ready), 64'(age == 0));
            chk("PSEL", 64'(PSEL), 64'(age >= 1 && age <= 1 + acc_len));
            chk("PENABLE", 64'(PENABLE), 64'(age >= 2 && age <= 1 + acc_len));
            chk("rsp_valid", 64'(rsp_valid), 64'(age == 2 + acc_len));
            chk("PADDR", 64'(PADDR), 64'(m_addr));
            chk("PWRITE", 64'(PWRITE), 64'(m_write));
            chk("PWDATA", 64'(PWDATA), 64'(m_wdata));
            chk("PSTRB", 64'(PSTRB), 64'(m_strb));
            chk("PPROT", 64'(PPROT), 64'(m_prot));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            chk("rsp_slverr", 64'(rsp_slverr), 64'(m_err));
            chk("rsp_timeout", 64'(rsp_timeout), 64'(m_to));
        end
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [2:0] p, input int waits, input logic err, input logic [31:0] rd,
                       input int rdly, output int lat, output logic [31:0] g_rdata,
                       output logic g_err, output logic g_to);
        int b;
        cur_waits = waits; cur_err = err; cur_rdata = rd;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        b = 0;
        while (!cmd_ready && b < 50) begin
            @(negedge PCLK);
            b++;
        end
        if (!cmd_ready) bound_fail("accept_wait");
        @(posedge PCLK); #1;
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
        lat = 0;
        do begin
            @(negedge PCLK);
            lat++;
        end while (!rsp_valid && lat < 100);
        if (!rsp_valid) bound_fail("rsp_wait");
        g_rdata = rsp_rdata; g_err = rsp_slverr; g_to = rsp_timeout;
        repeat (rdly) begin
            @(posedge PCLK); #1;
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b;
        logic [31:0] r;
        logic e, t;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        checking = 1'b1;
        @(negedge PCLK);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_psel", 64'(PSEL), 64'd0);

        txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 1'b0, 32'h0, 0, lat, r, e, t);
        chk("wr_latency", 64'(lat), 64'd3);
        chk("wr_slverr", 64'(e), 64'd0);
        chk("wr_rdata", 64'(r), 64'd0);

        txn(1'b0, 32'h20, $urandom, 4'hF, PPROT_PRIV, 3, 1'b0, 32'h1234_5678, 0, lat, r, e, t);
        chk("rd_latency", 64'(lat), 64'd6);
        chk("rd_rdata", 64'(r), 64'h1234_5678);

        txn(1'b0, 32'h30, $urandom, 4'h3, PPROT_NONSEC, 2, 1'b1, 32'hA5A5_0001, 0, lat, r, e, t);
        chk("err_slverr", 64'(e), 64'd1);
        chk("err_timeout", 64'(t), 64'd0);

        txn(1'b0, 32'h40, $urandom, 4'h0, PPROT_INSTR, 1000, 1'b0, 32'hFFFF_FFFF, 0, lat, r, e, t);
        chk("to_latency", 64'(lat), 64'd19);
        chk("to_slverr", 64'(e), 64'd1);
        chk("to_timeout", 64'(t), 64'd1);
        chk("to_rdata", 64'(r), 64'd0);

        txn(1'b0, 32'h44, $urandom, 4'h0, 3'b000, TO, 1'b0, 32'hCAFE_F00D, 0, lat, r, e, t);
        chk("edge_latency", 64'(lat), 64'd19);
        chk("edge_timeout", 64'(t), 64'd0);
        chk("edge_rdata", 64'(r), 64'hCAFE_F00D);

        txn(1'b1, 32'h50, 32'h0BAD_F00D, 4'h5, 3'b011, 0, 1'b0, 32'h0, 5, lat, r, e, t);
        chk("hold_latency", 64'(lat), 64'd3);
        for (int i = 0; i < 3; i++) begin
            txn(1'(i), 32'h60 + 32'(i * 4), $urandom, 4'hF, 3'b000, 0, 1'b0, $urandom, 0, lat, r, e, t);
            if (i > 0) chk("b2b_gap", 64'(gap), 64'd4);
        end

        cur_waits = 10; cur_err = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h7777_7777;
        cmd_strb = 4'hF; cmd_prot = 3'b001;
        b = 0;
        while (!cmd_ready && b < 50) begin
            @(negedge PCLK);
            b++;
        end
        if (!cmd_ready) bound_fail("rst_accept_wait");
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(posedge PCLK); #1;
        end
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("rst_mid_psel", 64'(PSEL), 64'd0);
        chk("rst_mid_paddr", 64'(PADDR), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        repeat (20) @(negedge PCLK);
        @(posedge PCLK); #1;
        txn(1'b0, 32'h80, $urandom, 4'hF, 3'b010, 1, 1'b0, 32'h8888_0000, 0, lat, r, e, t);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_rdata", 64'(r), 64'h8888_0000);

        for (int i = 0; i < 150; i++) begin
            int wt;
            wt = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 4)) : int'($urandom_range(14, 19));
            txn(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom), wt, 1'($urandom),
                $urandom, int'($urandom_range(0, 3)), lat, r, e, t);
            repeat ($urandom_range(0, 2)) begin
                @(posedge PCLK); #1;
            end
        end

        repeat (3) @(negedge PCLK);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
